// File: rtl/hba_pkg.sv
// Shared definitions for the HBA bus fabric: arbiter state encoding,
// address-width derivation and the watchdog read-fill pattern.
package hba_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Replicated across the data bus when the watchdog completes a hung read.
  localparam logic WD_FILL_BIT = 1'b1;

  function automatic int hba_addr_width(input int periph_w, input int reg_w);
    return periph_w + reg_w;
  endfunction

endpackage

// File: rtl/hba_rr_arbiter.sv
// Round-robin bus arbiter with a registered one-hot grant. The owner keeps the
// bus until it drops both its request and the shared select.
module hba_rr_arbiter
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] mrequest_i,
  input  logic                   select_i,
  output logic [NUM_MASTERS-1:0] mgrant_o
);

  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]          last_q, last_d;
  logic [2*NUM_MASTERS-1:0] req2;
  logic [NUM_MASTERS-1:0] rot, low, pick;
  logic [LW:0]            shamt;
  logic                   owner_req;

  // Rotate requests so the master after last_owner sits at bit 0, isolate the
  // lowest set bit, then rotate the one-hot result back into place.
  always_comb begin
    shamt = {1'b0, last_q} + (LW+1)'(1);
    req2  = {mrequest_i, mrequest_i};
    rot   = NUM_MASTERS'(req2 >> shamt);
    low   = rot & (~rot + NUM_MASTERS'(1));
    pick  = NUM_MASTERS'(({low, low} << shamt) >> NUM_MASTERS);
  end

  assign owner_req = |(mrequest_i & grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (|mrequest_i) state_d = ARB_OWNED;
      ARB_OWNED: if (!owner_req && !select_i) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        grant_d = pick;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (pick[i]) last_d = LW'(i);
        end
      end
      ARB_OWNED: if (!owner_req && !select_i) grant_d = '0;
      default:   grant_d = '0;
    endcase
  end

  assign mgrant_o = grant_q;

endmodule

// File: rtl/hba_bus_fabric.sv
// N-master / M-slot HBA interconnect: OR-combined bus, round-robin arbiter and
// a transfer watchdog enabled by defining HBA_FABRIC_WATCHDOG_EN.
module hba_bus_fabric
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS       = 2,
  parameter int NUM_SLAVES        = 5,
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = hba_addr_width(PERIPH_ADDR_WIDTH, REG_ADDR_WIDTH),
  parameter int XFER_TIMEOUT      = 255
) (
  input  logic                              hba_clk,
  input  logic                              hba_reset,
  input  logic [NUM_MASTERS-1:0]            hba_mrequest,
  output logic [NUM_MASTERS-1:0]            hba_mgrant,
  input  logic [NUM_MASTERS-1:0]            hba_select_master,
  input  logic [NUM_MASTERS-1:0]            hba_rnw_master,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] hba_abus_master,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] hba_dbus_master,
  input  logic [NUM_SLAVES-1:0]             hba_xferack_slave,
  input  logic [NUM_SLAVES*DBUS_WIDTH-1:0]  hba_dbus_slave,
  output logic                              hba_rnw,
  output logic                              hba_select,
  output logic [ADDR_WIDTH-1:0]             hba_abus,
  output logic [DBUS_WIDTH-1:0]             hba_dbus,
  output logic                              hba_xferack,
  output logic                              bus_err,
  output logic [ADDR_WIDTH-1:0]             bus_err_addr,
  input  logic                              bus_err_clr
);

  logic [ADDR_WIDTH-1:0] m_abus;
  logic [DBUS_WIDTH-1:0] m_dbus, s_dbus;
  logic                  slave_ack;
  logic                  wd_ack;

  always_comb begin
    m_abus = '0;
    m_dbus = '0;
    s_dbus = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_abus |= hba_abus_master[i*ADDR_WIDTH +: ADDR_WIDTH];
      m_dbus |= hba_dbus_master[i*DBUS_WIDTH +: DBUS_WIDTH];
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_dbus |= hba_dbus_slave[i*DBUS_WIDTH +: DBUS_WIDTH];
    end
  end

  assign hba_select  = |hba_select_master;
  assign hba_rnw     = |hba_rnw_master;
  assign hba_abus    = m_abus;
  assign slave_ack   = |hba_xferack_slave;
  assign hba_xferack = slave_ack | wd_ack;
  assign hba_dbus    = m_dbus | s_dbus |
                       ((wd_ack && hba_rnw) ? {DBUS_WIDTH{WD_FILL_BIT}} : '0);

  hba_rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_arb (
    .clk       (hba_clk),
    .rst_n     (hba_reset),
    .mrequest_i(hba_mrequest),
    .select_i  (hba_select),
    .mgrant_o  (hba_mgrant)
  );

`ifdef HBA_FABRIC_WATCHDOG_EN
  localparam int WD_W = $clog2(XFER_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(XFER_TIMEOUT - 1);
  // Parking value past the expiry point so a still-selected transfer acks once.
  localparam logic [WD_W-1:0] WD_SAT  = WD_W'(XFER_TIMEOUT);

  logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic                  bus_err_q, bus_err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  always_comb begin
    wd_ack   = hba_select && !slave_ack && (wd_cnt_q == WD_LAST);
    wd_cnt_d = wd_cnt_q;
    if (!hba_select || slave_ack) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_SAT) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    if (bus_err_clr) begin
      bus_err_d  = 1'b0;
      err_addr_d = '0;
    end else if (wd_ack && !bus_err_q) begin
      bus_err_d  = 1'b1;
      err_addr_d = hba_abus;
    end
  end

  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      wd_cnt_q   <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus_err      = bus_err_q;
  assign bus_err_addr = err_addr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus_err_clr;
  assign wd_ack         = 1'b0;
  assign bus_err        = 1'b0;
  assign bus_err_addr   = '0;
`endif

endmodule

// File: tb/tb_hba_bus_fabric.sv
// Scoreboard bench for hba_bus_fabric: directed scenarios plus randomized
// transactions checked against a behavioural model of arbitration and timeout.
module tb_hba_bus_fabric;

  localparam int NM = 2, NS = 5, DW = 8, PW = 4, RW = 8, AW = 12, TO = 8;
`ifdef HBA_FABRIC_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr;
  logic [NM-1:0] mreq, msel, mrnw;
  logic [NM*AW-1:0] mabus;
  logic [NM*DW-1:0] mdbus;
  logic [NS-1:0] sack;
  logic [NS*DW-1:0] sdbus;

  logic nx_rst, nx_clr;
  logic [NM-1:0] nx_mreq, nx_msel, nx_mrnw;
  logic [NM*AW-1:0] nx_mabus;
  logic [NM*DW-1:0] nx_mdbus;
  logic [NS-1:0] nx_sack;
  logic [NS*DW-1:0] nx_sdbus;

  logic [NM-1:0] mgrant;
  logic o_rnw, o_sel, o_ack, o_err;
  logic [AW-1:0] o_abus, o_eaddr;
  logic [DW-1:0] o_dbus;

  hba_bus_fabric #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .DBUS_WIDTH(DW),
    .PERIPH_ADDR_WIDTH(PW), .REG_ADDR_WIDTH(RW), .ADDR_WIDTH(AW),
    .XFER_TIMEOUT(TO)
  ) dut (
    .hba_clk(clk), .hba_reset(rst_n),
    .hba_mrequest(mreq), .hba_mgrant(mgrant),
    .hba_select_master(msel), .hba_rnw_master(mrnw),
    .hba_abus_master(mabus), .hba_dbus_master(mdbus),
    .hba_xferack_slave(sack), .hba_dbus_slave(sdbus),
    .hba_rnw(o_rnw), .hba_select(o_sel), .hba_abus(o_abus), .hba_dbus(o_dbus),
    .hba_xferack(o_ack), .bus_err(o_err), .bus_err_addr(o_eaddr),
    .bus_err_clr(clr)
  );

  typedef struct {
    logic [NM-1:0] grant;
    logic          sel, rnw, ack, err;
    logic [AW-1:0] abus, eaddr;
    logic [DW-1:0] dbus;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0;

  // Reference model state: who owns the bus, who owned it last, how long the
  // current transfer has gone unanswered and whether it was already timed out.
  int m_owner, m_last, m_busy;
  bit m_fired, m_err;
  logic [AW-1:0] m_eaddr;

  task automatic model_reset();
    m_owner = -1; m_last = NM - 1; m_busy = 0;
    m_fired = 0; m_err = 0; m_eaddr = '0;
  endtask

  function automatic logic [AW-1:0] bus_addr();
    logic [AW-1:0] a = '0;
    for (int i = 0; i < NM; i++) a |= mabus[i*AW +: AW];
    return a;
  endfunction

  function automatic bit exp_wd_ack();
    return WD_EN && (|msel) && !(|sack) && !m_fired && (m_busy == TO - 1);
  endfunction

  task automatic model_clock();
    bit wd, found;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wd = exp_wd_ack();
    if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= NM; k++) begin
        int c = (m_last + k) % NM;
        if (!found && mreq[c]) begin
          m_owner = c; m_last = c; found = 1;
        end
      end
    end else if (!mreq[m_owner] && !(|msel)) begin
      m_owner = -1;
    end
    if (!(|msel) || (|sack)) begin
      m_busy = 0; m_fired = 0;
    end else if (wd) begin
      m_fired = 1;
    end else begin
      m_busy++;
    end
    if (clr) begin
      m_err = 0; m_eaddr = '0;
    end else if (wd && !m_err) begin
      m_err = 1; m_eaddr = bus_addr();
    end
  endtask

  task automatic push_exp();
    exp_t e;
    logic [DW-1:0] d = '0;
    bit wd = exp_wd_ack();
    for (int i = 0; i < NM; i++) d |= mdbus[i*DW +: DW];
    for (int i = 0; i < NS; i++) d |= sdbus[i*DW +: DW];
    if (wd && (|mrnw)) d = '1;
    e.grant = (m_owner < 0) ? '0 : NM'(1 << m_owner);
    e.sel = |msel; e.rnw = |mrnw; e.abus = bus_addr(); e.dbus = d;
    e.ack = (|sack) || wd; e.err = m_err; e.eaddr = m_eaddr; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    mreq = nx_mreq; msel = nx_msel; mrnw = nx_mrnw; mabus = nx_mabus;
    mdbus = nx_mdbus; sack = nx_sack; sdbus = nx_sdbus;
    rst_n = nx_rst; clr = nx_clr; nx_clr = 1'b0;
    if (!rst_n) model_reset();
    cyc++;
    push_exp();
  endtask

  task automatic clear_xfer();
    nx_msel = '0; nx_mrnw = '0; nx_mabus = '0; nx_mdbus = '0;
    nx_sack = '0; nx_sdbus = '0;
  endtask

  // One transfer by master m: select held for ack_cyc cycles when a slot answers,
  // otherwise for hold cycles with no answer.
  task automatic xfer(input int m, input logic [AW-1:0] addr, input bit rnw,
                      input logic [DW-1:0] wdata, input int ack_slot,
                      input int ack_cyc, input logic [DW-1:0] rdata, input int hold);
    int len = (ack_slot >= 0) ? ack_cyc : hold;
    for (int c = 1; c <= len; c++) begin
      nx_msel[m] = 1'b1; nx_mrnw[m] = rnw;
      nx_mabus[m*AW +: AW] = addr;
      nx_mdbus[m*DW +: DW] = rnw ? '0 : wdata;
      nx_sack = '0; nx_sdbus = '0;
      if (ack_slot >= 0 && c == ack_cyc) begin
        nx_sack[ack_slot] = 1'b1;
        nx_sdbus[ack_slot*DW +: DW] = rdata;
      end
      step();
    end
    clear_xfer();
  endtask

  task automatic wait_grant(input int m);
    int n = 0;
    while (m_owner != m && n < 40) begin
      for (int k = 0; k < NM; k++) begin
        if (k != m) nx_mreq[k] = (m_owner == k) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      step();
      n++;
    end
    tests++;
    if (m_owner != m) begin
      fails++;
      $display("FAIL wait_grant: master %0d owner=%0d required=%0d", m, m_owner, m);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input int c);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mgrant", 32'(mgrant), 32'(e.grant), e.cyc);
        chk("select", 32'(o_sel), 32'(e.sel), e.cyc);
        chk("rnw", 32'(o_rnw), 32'(e.rnw), e.cyc);
        chk("abus", 32'(o_abus), 32'(e.abus), e.cyc);
        chk("dbus", 32'(o_dbus), 32'(e.dbus), e.cyc);
        chk("xferack", 32'(o_ack), 32'(e.ack), e.cyc);
        chk("bus_err", 32'(o_err), 32'(e.err), e.cyc);
        chk("bus_err_addr", 32'(o_eaddr), 32'(e.eaddr), e.cyc);
      end
    end
  end

  initial begin : stimulus
    nx_rst = 1'b0; nx_clr = 1'b0; nx_mreq = '0;
    clear_xfer();
    rst_n = 1'b0; clr = 1'b0; mreq = '0; msel = '0; mrnw = '0;
    mabus = '0; mdbus = '0; sack = '0; sdbus = '0;
    model_reset();
    step(); step();

    // Simultaneous requests after reset: master 0 first, master 1 after one idle cycle.
    nx_rst = 1'b1; nx_mreq = 2'b11;
    step(); step();
    xfer(0, 12'h233, 1'b0, 8'hC3, 2, 2, 8'h00, 0);
    nx_mreq[0] = 1'b0;
    step(); step(); step();

    // Master 1 keeps the bus while master 0 requests continuously.
    nx_mreq[0] = 1'b1;
    xfer(1, 12'h105, 1'b1, 8'h00, 1, 3, 8'h11, 0);
    step(); step(); step();
    nx_mreq[1] = 1'b0;
    step(); step(); step();

    // Read of slot 3 answered on cycle 2.
    xfer(0, 12'h305, 1'b1, 8'h00, 3, 2, 8'h5A, 0);
    step();

    // Two timeouts on an unpopulated slot, then clear.
    xfer(0, 12'h710, 1'b1, 8'h00, -1, 0, 8'h00, 10);
    step();
    xfer(0, 12'h720, 1'b1, 8'h00, -1, 0, 8'h00, 9);
    step();
    nx_clr = 1'b1;
    step(); step();

    // Slave ack lands exactly on the expiry cycle.
    xfer(0, 12'h104, 1'b1, 8'h00, 1, TO, 8'h66, 0);
    step();

    // Reset mid-transfer while owned.
    nx_msel[0] = 1'b1; nx_mrnw[0] = 1'b1; nx_mabus[0 +: AW] = 12'h7AA;
    step(); step(); step();
    nx_rst = 1'b0;
    step();
    nx_mreq = '0;
    clear_xfer();
    step();
    nx_rst = 1'b1; nx_mreq = 2'b10;
    step(); step();
    xfer(1, 12'h2F0, 1'b0, 8'h3C, 2, 1, 8'h00, 0);
    nx_mreq = '0;
    step(); step();

    // Randomized transactions across populated and unpopulated slots.
    for (int t = 0; t < 120; t++) begin
      int m, slot, dly;
      logic [AW-1:0] a;
      bit r;
      m = $urandom_range(0, NM - 1);
      if ($urandom_range(0, 9) == 0) nx_clr = 1'b1;
      nx_mreq[m] = 1'b1;
      wait_grant(m);
      slot = $urandom_range(0, 7);
      a = {4'(slot), 8'($urandom)};
      r = 1'($urandom_range(0, 1));
      dly = $urandom_range(1, TO + 2);
      xfer(m, a, r, 8'($urandom), (slot < NS) ? slot : -1, dly, 8'($urandom), dly);
      if ($urandom_range(0, 1) == 1) nx_mreq[m] = 1'b0;
      step();
    end

    nx_mreq = '0;
    clear_xfer();
    step(); step(); step();
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hba_bus_fabric.md
# hba_bus_fabric

Parametrised HBA bus interconnect that replaces the fixed single-master OR-tree plus arbiter pair in a system top. It combines N masters and M slave slots onto one shared HBA bus, grants bus ownership by round-robin arbitration with a registered grant, and OR-reduces slave read data and acknowledges. It also runs a transfer watchdog that completes hung transfers with an error response, so a missing or mis-addressed slot can no longer lock the bus.

## Interface
- NUM_MASTERS, 2: number of bus masters, 1..4.
- NUM_SLAVES, 5: number of populated slave slots, 1..16; unpopulated slots contribute zero.
- DBUS_WIDTH, 8: data bus width.
- PERIPH_ADDR_WIDTH, 4: slot field width of the address.
- REG_ADDR_WIDTH, 8: register field width of the address.
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH: full address width.
- XFER_TIMEOUT, 255: watchdog limit in cycles, 2..65535.

Ports:
- hba_clk  in  1  bus clock.
- hba_reset  in  1  asynchronous, active-low reset.
- hba_mrequest  in  NUM_MASTERS  per-master bus request.
- hba_mgrant  out  NUM_MASTERS  one-hot registered grant.
- hba_select_master  in  NUM_MASTERS  per-master select; zero when not granted.
- hba_rnw_master  in  NUM_MASTERS  per-master read/not-write; zero when inactive.
- hba_abus_master  in  NUM_MASTERS*ADDR_WIDTH  packed master addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- hba_dbus_master  in  NUM_MASTERS*DBUS_WIDTH  packed master write data.
- hba_xferack_slave  in  NUM_SLAVES  per-slot acknowledge.
- hba_dbus_slave  in  NUM_SLAVES*DBUS_WIDTH  packed slot read data.
- hba_rnw, hba_select  out  1  combined bus controls.
- hba_abus  out  ADDR_WIDTH  combined address.
- hba_dbus  out  DBUS_WIDTH  combined data: masters OR slaves OR watchdog fill.
- hba_xferack  out  1  combined acknowledge.
- bus_err  out  1  sticky timeout flag.
- bus_err_addr  out  ADDR_WIDTH  address of the first timed-out transfer.
- bus_err_clr  in  1  one-cycle pulse that clears bus_err and bus_err_addr.

## Operation
- Combining:
  - hba_select, hba_rnw, hba_abus and the master part of hba_dbus are the bitwise OR of all master inputs.
  - The slave part of hba_dbus is the OR of all hba_dbus_slave slices.
  - hba_xferack is the OR of hba_xferack_slave and the watchdog ack.
- Arbiter FSM, two states:
  - IDLE: hba_mgrant = 0. If any hba_mrequest bit is set, pick the first requester after last_owner (modulo NUM_MASTERS), register the one-hot grant, update last_owner, and go to OWNED.
  - OWNED: hold the grant. When the owner's hba_mrequest is 0 and hba_select is 0, clear the grant and return to IDLE.
  - Requests from non-owners are ignored while in OWNED.
  - NUM_MASTERS=1 degenerates to grant-follows-request with the same one-cycle latency.
- Watchdog:
  - wd_cnt counts cycles with hba_select=1 and no slave ack.
  - Clear wd_cnt on any slave ack or when hba_select=0.
  - When wd_cnt reaches XFER_TIMEOUT-1 and no slave ack arrives in that cycle, assert wd_ack for one cycle.
  - During that cycle, drive hba_dbus to all-ones when hba_rnw=1.
  - If bus_err=0, set bus_err and capture hba_abus into bus_err_addr.
  - wd_cnt saturates after wd_ack until hba_select falls, so there is no second ack.
- bus_err_clr has priority over a new capture in the same cycle.

## Timing
- Reset values: hba_mgrant=0, bus_err=0, bus_err_addr=0, wd_cnt=0, last_owner=NUM_MASTERS-1 (master 0 wins first).
- Request to grant: 1 cycle (hba_mgrant registered).
- Grant to grant: minimum 1 IDLE cycle between owners.
- Combined bus outputs are combinational, zero-latency from their inputs.
- Watchdog ack fires in cycle XFER_TIMEOUT counted from the rising cycle of hba_select (cycle 1).
- A slave ack in the same cycle as the watchdog expiry wins: no wd_ack, no error.
- Reset asserted mid-transfer forces IDLE, drops the grant and clears the watchdog asynchronously.

## Configuration
- HBA_FABRIC_WATCHDOG_EN defined: watchdog, bus_err and bus_err_addr are as described.
- Not defined: no counter logic. bus_err and bus_err_addr are tied to 0, bus_err_clr is ignored, and hba_xferack is the pure slave OR.

## Structure
- Shared package hba_pkg holds:
  - arbiter state encoding (IDLE, OWNED);
  - ADDR_WIDTH derivation;
  - the watchdog fill constant (all-ones).
- One sub-module, hba_rr_arbiter: round-robin pick plus the IDLE/OWNED FSM, parametrised by NUM_MASTERS.
- OR reductions and the watchdog stay in hba_bus_fabric.

## Test plan
- Reset release, master 0 and master 1 request in the same cycle -> hba_mgrant=01 one cycle later; after master 0 releases, one IDLE cycle, then hba_mgrant=10.
- Master 1 holds ownership while master 0 requests continuously -> master 0 is not granted until master 1 drops request and select.
- Read of slot 3 with slot 3 returning 0x5A and an ack on cycle 2 -> hba_dbus=0x5A, hba_xferack=1 in that cycle, bus_err stays 0.
- XFER_TIMEOUT=8, read of unpopulated slot address 0x7_10 -> hba_xferack pulses on cycle 8 with hba_dbus=0xFF, bus_err=1, bus_err_addr=0x710; a second timeout at 0x720 leaves bus_err_addr=0x710; bus_err_clr clears both.
- Slave ack arrives exactly on cycle XFER_TIMEOUT -> single hba_xferack pulse, bus_err=0.
- hba_reset pulled low mid-transfer while owned -> hba_mgrant=0 immediately; after release, a new request is granted one cycle later.
